// File: rtl/pc_fetch_sequencer_if.sv
// pc_fetch_sequencer_if: imem fetch, commit and status bus; master = sequencer, slave = memory/datapath side
interface pc_fetch_sequencer_if #(parameter int XLEN = 32);
  logic            IMEM_REQ;
  logic [XLEN-1:0] IMEM_ADDR;
  logic            IMEM_RVALID;
  logic [XLEN-1:0] IMEM_RDATA;
  logic [XLEN-1:0] INSTR;
  logic            INSTR_VALID;
  logic            STALL;
  logic            PC_Sel;
  logic [XLEN-1:0] BRANCH_TARGET;
  logic [XLEN-1:0] PC;
  logic [XLEN-1:0] PC_PLUS4;
  logic [31:0]     INSTRET;
  logic            ERR;
  logic [1:0]      ERR_CODE;
  modport master (
    output IMEM_REQ, IMEM_ADDR, INSTR, INSTR_VALID, PC, PC_PLUS4, INSTRET, ERR, ERR_CODE,
    input  IMEM_RVALID, IMEM_RDATA, STALL, PC_Sel, BRANCH_TARGET
  );
  modport slave (
    input  IMEM_REQ, IMEM_ADDR, INSTR, INSTR_VALID, PC, PC_PLUS4, INSTRET, ERR, ERR_CODE,
    output IMEM_RVALID, IMEM_RDATA, STALL, PC_Sel, BRANCH_TARGET
  );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: RV32I fetch/commit sequencer; CLK, RSTN (async low) plus bus (imem req/addr/rvalid/rdata, instr/valid/stall, pc_sel/target, pc/pc_plus4/instret/err/err_code)
module pc_fetch_sequencer #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              MAX_WAIT = 15
) (
  input logic                 CLK,
  input logic                 RSTN,
  pc_fetch_sequencer_if.master bus
);
  typedef enum logic [2:0] {S_INIT, S_FETCH, S_WAIT, S_COMMIT, S_ERROR} state_t;
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);
  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, instr_q, instr_d;
  logic [31:0]     instret_q, instret_d;
  logic            err_q, err_d;
  logic [1:0]      code_q, code_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] pc_plus4;
  assign pc_plus4 = pc_q + XLEN'(4);
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    instret_d = instret_q;
    err_d     = err_q;
    code_d    = code_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_INIT: state_d = S_FETCH;
      S_FETCH: begin
        cnt_d   = '0;
        instr_d = bus.IMEM_RVALID ? bus.IMEM_RDATA : instr_q;
        state_d = bus.IMEM_RVALID ? S_COMMIT : S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (bus.IMEM_RVALID) begin
          instr_d = bus.IMEM_RDATA;
          state_d = S_COMMIT;
        end else if (cnt_q == WAIT_LAST) begin
          err_d   = 1'b1;
          code_d  = 2'b01;
          state_d = S_ERROR;
        end
      end
      S_COMMIT: begin
        if (!bus.STALL) begin
          if (bus.PC_Sel && bus.BRANCH_TARGET[1]) begin
            err_d   = 1'b1;
            code_d  = 2'b10;
            state_d = S_ERROR;
          end else begin
            pc_d      = bus.PC_Sel ? {bus.BRANCH_TARGET[XLEN-1:1], 1'b0} : pc_plus4;
            instret_d = instret_q + 32'd1;
            state_d   = S_FETCH;
          end
        end
      end
      default: ;
    endcase
  end
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= S_INIT;
      pc_q      <= RESET_PC;
      instr_q   <= XLEN'(32'h0000_0013);
      instret_q <= '0;
      err_q     <= 1'b0;
      code_q    <= 2'b00;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      instret_q <= instret_d;
      err_q     <= err_d;
      code_q    <= code_d;
      cnt_q     <= cnt_d;
    end
  end
  assign bus.IMEM_REQ    = state_q == S_FETCH;
  assign bus.IMEM_ADDR   = pc_q;
  assign bus.INSTR       = instr_q;
  assign bus.INSTR_VALID = state_q == S_COMMIT;
  assign bus.PC          = pc_q;
  assign bus.PC_PLUS4    = pc_plus4;
  assign bus.INSTRET     = instret_q;
  assign bus.ERR         = err_q;
  assign bus.ERR_CODE    = code_q;
endmodule
